seg7_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver for the dice/I2C tile. It consumes BCD digit values from the roll logic and produces registered segment and common-drive outputs for up to 8 digits. Features: leading-zero blanking, 16-level brightness PWM with inter-digit dead time, an inactivity timeout and pin-selectable output polarity. It sits directly downstream of the digit counters and drives the `uo_out` / `uio_out` pads.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_lut.sv | 9 +
 rtl/seg7_scan_driver.sv | 90 +++++++++
 tb/tb_seg7_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions and digit encodings for the seven-segment scan driver
package seg7_pkg;
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    localparam logic [7:0] SEG_DASH  = 8'(1 << SEG_G);
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Non-BCD values (10-15) render as a dash so bad data is visible, not silent
    function automatic logic [7:0] seg7_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg7_digit = 8'h3F;
            4'd1:    seg7_digit = 8'h06;
            4'd2:    seg7_digit = 8'h5B;
            4'd3:    seg7_digit = 8'h4F;
            4'd4:    seg7_digit = 8'h66;
            4'd5:    seg7_digit = 8'h6D;
            4'd6:    seg7_digit = 8'h7D;
            4'd7:    seg7_digit = 8'h07;
            4'd8:    seg7_digit = 8'h7F;
            4'd9:    seg7_digit = 8'h6F;
            default: seg7_digit = SEG_DASH;
        endcase
    endfunction
endpackage

// File: rtl/seg7_lut.sv
// seg7_lut: combinational BCD-to-segment decoder, dp always off
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);
    assign seg = seg7_digit(digit);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment driver with blanking, PWM, timeout and polarity
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    force_blank,
    input  logic [3:0]              bright,
    input  logic                    seg_pol,
    input  logic                    com_pol,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   com_out,
    output logic                    display_on
);
    localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [3:0]              sub;
    logic [SW-1:0]           slot;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [7:0]              tcnt;
    logic [7:0]              seg_r;
    logic [7:0]              lut_seg;
    logic [NUM_DIGITS-1:0]   com_r;
    logic [NUM_DIGITS-1:0]   slot_hot;
    logic [NUM_DIGITS-1:0]   lz;
    logic [3:0]              cur;
    logic                    nz;
    logic                    en;

    // lz[k]: digit k and every more-significant digit are zero
    always_comb begin
        cur      = 4'd0;
        slot_hot = '0;
        lz       = '0;
        nz       = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (slot == SW'(k)) begin
                cur         = shadow[k*4 +: 4];
                slot_hot[k] = 1'b1;
            end
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            nz    = nz | (shadow[k*4 +: 4] != 4'd0);
            lz[k] = ~nz;
        end
    end

    seg7_lut u_lut (
        .digit (cur),
        .seg   (lut_seg)
    );

    assign display_on = tcnt != 8'd0;
    assign en = sub != 4'd0 && sub <= bright && display_on && !force_blank && !(|(lz & slot_hot));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub     <= 4'd0;
            slot    <= '0;
            pending <= '0;
            shadow  <= '0;
            tcnt    <= 8'd0;
            seg_r   <= SEG_BLANK;
            com_r   <= '0;
        end else begin
            sub <= sub + 4'd1;
            if (sub == 4'd15)
                slot <= slot == SW'(NUM_DIGITS - 1) ? '0 : slot + 1'b1;
            if (load)
                pending <= digits_in;
            if (sub == 4'd15)
                shadow <= load ? digits_in : pending;
            if (load)
                tcnt <= 8'(TIMEOUT_TICKS);
            else if (tick && display_on)
                tcnt <= tcnt - 8'd1;
            seg_r <= en ? lut_seg : SEG_BLANK;
            com_r <= en ? slot_hot : '0;
        end
    end

    assign seg_out = seg_r ^ {8{~seg_pol}};
    assign com_out = com_r ^ {NUM_DIGITS{~com_pol}};
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for the two-digit scan driver
module tb_seg7_scan_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic       force_blank = 1'b0;
    logic       seg_pol = 1'b1;
    logic       com_pol = 1'b1;
    logic [7:0] digits_in = 8'h00;
    logic [3:0] bright = 4'd15;
    logic [7:0] seg_out;
    logic [1:0] com_out;
    logic       display_on;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] m_sub;
    logic       m_slot;

    seg7_scan_driver #(.NUM_DIGITS(2), .TIMEOUT_TICKS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .digits_in   (digits_in),
        .load        (load),
        .force_blank (force_blank),
        .bright      (bright),
        .seg_pol     (seg_pol),
        .com_pol     (com_pol),
        .seg_out     (seg_out),
        .com_out     (com_out),
        .display_on  (display_on)
    );

    always #5 clk = ~clk;

    // Expected scan position, used only to align checks with slot boundaries
    always @(posedge clk or posedge rst)
        if (rst) begin
            m_sub  <= 4'd0;
            m_slot <= 1'b0;
        end else begin
            m_sub <= m_sub + 4'd1;
            if (m_sub == 4'd15)
                m_slot <= ~m_slot;
        end

    task automatic wait_state(input logic s, input logic [3:0] b);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(m_slot == s && m_sub == b) && g < 64);
        if (g >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_state: scan position %0d/%0d not reached", s, b);
        end
    endtask

    task automatic pulse_load(input logic [7:0] v);
        digits_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Pins at sample i show the decision made at (slot i/16, sub i%16)
    task automatic check_frame(input string name, input logic [7:0] s0, input logic [1:0] c0,
                               input logic [7:0] s1, input logic [1:0] c1, input logic [3:0] br);
        logic [7:0] es;
        logic [1:0] ec;
        logic       on;
        wait_state(1'b0, 4'd1);
        for (int i = 0; i < 32; i++) begin
            on = (i % 16) >= 1 && (i % 16) <= int'(br);
            es = !on ? 8'h00 : (i < 16 ? s0 : s1);
            ec = !on ? 2'b00 : (i < 16 ? c0 : c1);
            n_cmp++;
            if (seg_out !== es || com_out !== ec) begin
                n_bad++;
                $display("FAIL %s cycle %0d: seg_out=%h com_out=%b, required seg_out=%h com_out=%b",
                         name, i, seg_out, com_out, es, ec);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_dark(input string name, input int cycles, input logic [7:0] es,
                              input logic [1:0] ec, input logic eon);
        for (int i = 0; i < cycles; i++) begin
            n_cmp++;
            if (seg_out !== es || com_out !== ec || display_on !== eon) begin
                n_bad++;
                $display("FAIL %s cycle %0d: seg_out=%h com_out=%b display_on=%b, required %h %b %b",
                         name, i, seg_out, com_out, display_on, es, ec, eon);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_on(input string name, input logic eon);
        n_cmp++;
        if (display_on !== eon) begin
            n_bad++;
            $display("FAIL %s: display_on=%b, required %b", name, display_on, eon);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_dark("reset_held", 1, 8'h00, 2'b00, 1'b0);
        rst = 1'b0;
        check_dark("reset_released_dark", 32, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic test_basic();
        bright = 4'd15;
        pulse_load(8'h42);
        check_on("basic_display_on", 1'b1);
        check_frame("basic_42", 8'h5B, 2'b01, 8'h66, 2'b10, 4'd15);
    endtask

    task automatic test_blanking();
        pulse_load(8'h07);
        check_frame("lzb_07", 8'h07, 2'b01, 8'h00, 2'b00, 4'd15);
        pulse_load(8'h00);
        check_frame("lzb_00", 8'h3F, 2'b01, 8'h00, 2'b00, 4'd15);
    endtask

    task automatic test_bright();
        pulse_load(8'h42);
        bright = 4'd4;
        check_frame("bright_4", 8'h5B, 2'b01, 8'h66, 2'b10, 4'd4);
        bright = 4'd0;
        check_frame("bright_0", 8'h00, 2'b00, 8'h00, 2'b00, 4'd0);
        bright = 4'd15;
    endtask

    task automatic test_data();
        pulse_load(8'hAB);
        check_frame("dash_AB", 8'h40, 2'b01, 8'h40, 2'b10, 4'd15);
        force_blank = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (com_out !== 2'b00) begin
                n_bad++;
                $display("FAIL force_blank cycle %0d: com_out=%b, required 00", i, com_out);
            end
        end
        force_blank = 1'b0;
        check_frame("resume_in_phase", 8'h40, 2'b01, 8'h40, 2'b10, 4'd15);
        wait_state(1'b1, 4'd15);
        pulse_load(8'h42);
        check_frame("load_at_sub15", 8'h5B, 2'b01, 8'h66, 2'b10, 4'd15);
    endtask

    task automatic test_timeout();
        pulse_tick();
        check_on("timeout_tick1", 1'b1);
        pulse_tick();
        check_on("timeout_tick2", 1'b1);
        pulse_tick();
        check_on("timeout_tick3", 1'b0);
        @(negedge clk);
        check_dark("timeout_dark", 32, 8'h00, 2'b00, 1'b0);
        digits_in = 8'h42;
        load = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        load = 1'b0;
        tick = 1'b0;
        check_on("load_tick_reload", 1'b1);
        pulse_tick();
        pulse_tick();
        check_on("reload_tick2", 1'b1);
        pulse_tick();
        check_on("reload_tick3", 1'b0);
        pulse_load(8'h42);
    endtask

    task automatic test_pol_reset();
        seg_pol = 1'b0;
        com_pol = 1'b0;
        wait_state(1'b0, 4'd5);
        n_cmp++;
        if (seg_out !== 8'hA4 || com_out !== 2'b10) begin
            n_bad++;
            $display("FAIL pol_low_active: seg_out=%h com_out=%b, required A4 10", seg_out, com_out);
        end
        #1 rst = 1'b1;
        #1;
        check_dark("reset_mid_slot", 1, 8'hFF, 2'b11, 1'b0);
        repeat (2) @(negedge clk);
        check_dark("reset_held_low_pol", 2, 8'hFF, 2'b11, 1'b0);
        rst = 1'b0;
        check_dark("after_reset_low_pol", 32, 8'hFF, 2'b11, 1'b0);
        seg_pol = 1'b1;
        com_pol = 1'b1;
        pulse_load(8'h42);
        check_frame("after_reset_load", 8'h5B, 2'b01, 8'h66, 2'b10, 4'd15);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_bright();
        test_data();
        test_timeout();
        test_pol_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
